// File: rtl/scrn_timing_gen.sv
// scrn_timing_gen: video timing generator with CEA presets, custom mode and frame-boundary mode switching.
// Optional line-match interrupt built when SCRN_TIMING_LINE_IRQ_EN is defined.
module scrn_timing_gen #(
    parameter int CW = 12
) (
    input  logic          clk_pix,
    input  logic          rst_pix,
    input  logic [1:0]    res,
    input  logic          cfg_load,
    input  logic [CW-1:0] cfg_h_act,
    input  logic [CW-1:0] cfg_h_fp,
    input  logic [CW-1:0] cfg_h_sync,
    input  logic [CW-1:0] cfg_h_bp,
    input  logic [CW-1:0] cfg_v_act,
    input  logic [CW-1:0] cfg_v_fp,
    input  logic [CW-1:0] cfg_v_sync,
    input  logic [CW-1:0] cfg_v_bp,
    input  logic          cfg_hpol,
    input  logic          cfg_vpol,
    input  logic [CW-1:0] irq_line,
    output logic [CW-1:0] sx,
    output logic [CW-1:0] sy,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          frame_start,
    output logic          line_start,
    output logic          line_irq
);
    localparam logic [CW-1:0] ONE_C = 1;
    localparam logic [CW:0]   ONE_W = 1;
    logic [7:0][CW-1:0] pend, cust;
    logic [1:0]         pend_pol, cust_pol;
    logic [1:0]         mode;
    logic [CW-1:0]      hc, vc;
    logic [CW-1:0]      ha, hf, hs, hb, va, vf, vs, vb;
    logic               hp, vp;
    logic [CW:0]        hx, vx, h1, h2, ht, v1, v2, vt;
    logic               h_last, v_last, irq_hit;
    always_comb begin
        {ha, hf, hs, hb, va, vf, vs, vb, hp, vp} =
            mode == 2'd0 ? {CW'(640), CW'(16), CW'(96), CW'(48), CW'(480), CW'(10), CW'(2), CW'(33), 2'b00} :
            mode == 2'd1 ? {CW'(1920), CW'(88), CW'(44), CW'(148), CW'(1080), CW'(4), CW'(5), CW'(36), 2'b11} :
            mode == 2'd2 ? {CW'(1280), CW'(110), CW'(40), CW'(220), CW'(720), CW'(5), CW'(5), CW'(20), 2'b11} :
                           {cust, cust_pol};
    end
    assign hx = {1'b0, hc};
    assign vx = {1'b0, vc};
    assign h1 = {1'b0, ha} + {1'b0, hf};
    assign h2 = h1 + {1'b0, hs};
    assign ht = h2 + {1'b0, hb};
    assign v1 = {1'b0, va} + {1'b0, vf};
    assign v2 = v1 + {1'b0, vs};
    assign vt = v2 + {1'b0, vb};
    assign h_last = hx == ht - ONE_W;
    assign v_last = vx == vt - ONE_W;
`ifdef SCRN_TIMING_LINE_IRQ_EN
    assign irq_hit = hc == '0 && vc == irq_line;
`else
    logic unused_irq;
    assign unused_irq = ^irq_line;
    assign irq_hit = 1'b0;
`endif
    // Outputs register the decode of the current counters, so they trail hc/vc by one cycle.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            hc          <= '0;
            vc          <= '0;
            mode        <= 2'd0;
            pend        <= '0;
            pend_pol    <= 2'b00;
            cust        <= '0;
            cust_pol    <= 2'b00;
            sx          <= '0;
            sy          <= '0;
            de          <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            line_irq    <= 1'b0;
        end else begin
            if (cfg_load) begin
                pend     <= {cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp, cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp};
                pend_pol <= {cfg_hpol, cfg_vpol};
            end
            hc <= h_last ? '0 : hc + ONE_C;
            if (h_last)
                vc <= v_last ? '0 : vc + ONE_C;
            if (h_last && v_last) begin
                mode     <= res;
                cust     <= pend;
                cust_pol <= pend_pol;
            end
            sx          <= hc;
            sy          <= vc;
            de          <= hx < {1'b0, ha} && vx < {1'b0, va};
            hsync       <= ~((hx >= h1 && hx < h2) ^ hp);
            vsync       <= ~((vx >= v1 && vx < v2) ^ vp);
            frame_start <= hc == '0 && vc == '0;
            line_start  <= hc == '0;
            line_irq    <= irq_hit;
        end
    end
endmodule

// File: tb/tb_scrn_timing_gen.sv
// tb_scrn_timing_gen: checks every output cycle against a pixel/frame-level model of scrn_timing_gen.
module tb_scrn_timing_gen;
    localparam int CW = 12;
`ifdef SCRN_TIMING_LINE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif
    logic          clk_pix = 1'b0, rst_pix = 1'b1, cfg_load = 1'b0;
    logic [1:0]    res = 2'd0;
    logic [CW-1:0] cfg_h_act = '0, cfg_h_fp = '0, cfg_h_sync = '0, cfg_h_bp = '0;
    logic [CW-1:0] cfg_v_act = '0, cfg_v_fp = '0, cfg_v_sync = '0, cfg_v_bp = '0;
    logic          cfg_hpol = 1'b0, cfg_vpol = 1'b0;
    logic [CW-1:0] irq_line = '0;
    logic [CW-1:0] sx, sy;
    logic          hsync, vsync, de, frame_start, line_start, line_irq;
    scrn_timing_gen #(.CW(CW)) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .res(res), .cfg_load(cfg_load),
        .cfg_h_act(cfg_h_act), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
        .cfg_v_act(cfg_v_act), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
        .cfg_hpol(cfg_hpol), .cfg_vpol(cfg_vpol), .irq_line(irq_line),
        .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync), .de(de),
        .frame_start(frame_start), .line_start(line_start), .line_irq(line_irq)
    );
    always #5 clk_pix = ~clk_pix;
    int vectors = 0, miscompares = 0;
    // Model state: next pixel to be shown, the mode showing it, and the custom sets.
    // Timing sets are {h_act, h_fp, h_sync, h_bp, v_act, v_fp, v_sync, v_bp, hpol, vpol}.
    int px = 0, py = 0, m = 0;
    int cur[10] = '{default: 0};
    int pend[10] = '{default: 0};
    int preset[3][10] = '{'{640, 16, 96, 48, 480, 10, 2, 33, 0, 0},
                          '{1920, 88, 44, 148, 1080, 4, 5, 36, 1, 1},
                          '{1280, 110, 40, 220, 720, 5, 5, 20, 1, 1}};
    function automatic int tv(int i);
        return m == 3 ? cur[i] : preset[m][i];
    endfunction
    function automatic int h_tot();
        return tv(0) + tv(1) + tv(2) + tv(3);
    endfunction
    function automatic int v_tot();
        return tv(4) + tv(5) + tv(6) + tv(7);
    endfunction
    function automatic bit at_last();
        return px == h_tot() - 1 && py == v_tot() - 1;
    endfunction
    task automatic step(input string tag);
        logic r, ld;
        logic [1:0] rs;
        int nc[10];
        int il, ht, vt, xs, ys;
        bit hs_in, vs_in, last;
        logic [2*CW+5:0] exp_v, got;
        r  = rst_pix;
        ld = cfg_load;
        rs = res;
        il = int'(irq_line);
        nc = '{int'(cfg_h_act), int'(cfg_h_fp), int'(cfg_h_sync), int'(cfg_h_bp),
               int'(cfg_v_act), int'(cfg_v_fp), int'(cfg_v_sync), int'(cfg_v_bp),
               int'(cfg_hpol), int'(cfg_vpol)};
        @(posedge clk_pix);
        #1;
        xs = px;
        ys = py;
        if (r) begin
            px = 0; py = 0; m = 0;
            pend = '{default: 0};
            cur  = '{default: 0};
            exp_v = {CW'(0), CW'(0), 1'b1, 1'b1, 4'b0000};
        end else begin
            ht = h_tot();
            vt = v_tot();
            hs_in = px >= tv(0) + tv(1) && px < tv(0) + tv(1) + tv(2);
            vs_in = py >= tv(4) + tv(5) && py < tv(4) + tv(5) + tv(6);
            exp_v = {CW'(px), CW'(py),
                     hs_in ? tv(8) != 0 : tv(8) == 0,
                     vs_in ? tv(9) != 0 : tv(9) == 0,
                     px < tv(0) && py < tv(4),
                     px == 0 && py == 0,
                     px == 0,
                     IRQ_EN && px == 0 && py == il};
            last = px == ht - 1 && py == vt - 1;
            if (last) begin
                m = int'(rs);
                cur = pend;
            end
            if (ld) pend = nc;
            if (px == ht - 1) begin
                px = 0;
                py = py == vt - 1 ? 0 : py + 1;
            end else px++;
        end
        got = {sx, sy, hsync, vsync, de, frame_start, line_start, line_irq};
        vectors++;
        assert (got === exp_v) else begin
            miscompares++;
            $error("FAIL %s pixel(%0d,%0d): got sx/sy/hs/vs/de/fs/ls/li=%h expected %h", tag, xs, ys, got, exp_v);
        end
    endtask
    task automatic drive_cfg(input int c[10]);
        {cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp} = {CW'(c[0]), CW'(c[1]), CW'(c[2]), CW'(c[3])};
        {cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp} = {CW'(c[4]), CW'(c[5]), CW'(c[6]), CW'(c[7])};
        cfg_hpol = c[8] != 0;
        cfg_vpol = c[9] != 0;
    endtask
    task automatic load_cfg(input int c[10], input string tag);
        drive_cfg(c);
        cfg_load = 1'b1;
        step(tag);
        cfg_load = 1'b0;
    endtask
    task automatic run_to_boundary(input string tag);
        int n = 0;
        while (!at_last() && n < 500000) begin
            step(tag);
            n++;
        end
        step({tag, "_edge"});
    endtask
    task automatic rand_cfg(output int c[10]);
        c = '{$urandom_range(1, 10), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(1, 8), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 1), $urandom_range(0, 1)};
    endtask
    int cfg_a[10] = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 0};
    int cfg_b[10] = '{5, 0, 3, 1, 3, 2, 0, 1, 0, 1};
    int cfg_c[10] = '{6, 1, 0, 2, 2, 0, 2, 0, 1, 1};
    int rc[10];
    initial begin
        irq_line = CW'(1);
        step("reset");
        step("reset");
        rst_pix = 1'b0;
        repeat (1700) step("m0_lines");
        rst_pix = 1'b1;
        step("rst_mid_m0");
        rst_pix = 1'b0;
        for (int i = 0; i < 300; i++) begin
            res = 2'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rand_cfg(rc);
                drive_cfg(rc);
                cfg_load = 1'b1;
            end
            step("m0_noise");
            cfg_load = 1'b0;
        end
        load_cfg(cfg_a, "load_a");
        res = 2'd3;
        irq_line = CW'(3);
        run_to_boundary("m0_frame");
        repeat (3 * 98) step("custom_a");
        load_cfg(cfg_c, "load_c");
        res = 2'd1;
        repeat (20) step("res_glitch");
        res = 2'd3;
        run_to_boundary("a_to_c");
        load_cfg(cfg_b, "bnd_load_b");
        repeat (2 * 30) step("c_then_b");
        irq_line = CW'(9);
        for (int k = 0; k < 6; k++) begin
            rand_cfg(rc);
            load_cfg(rc, "rand_load");
            irq_line = CW'($urandom_range(0, 9));
            res = 2'($urandom);
            step("rand_res");
            res = 2'd3;
            run_to_boundary("rand_frame");
            repeat (250) step("rand_run");
        end
        repeat (5) step("pre_rst");
        rst_pix = 1'b1;
        step("rst_custom");
        rst_pix = 1'b0;
        repeat (1000) step("after_rst");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/scrn_timing_gen.md
# scrn_timing_gen

Parametrised video timing generator. It produces pixel/line coordinates, sync and data-enable for the display pipeline in the `clk_pix` domain. It adds three behaviours: three CEA presets plus one runtime-programmable custom mode; per-mode sync polarity; and glitch-free mode switching applied only at frame boundaries. It also emits frame/line start strobes and an optional line-match interrupt for the framebuffer fetch and display controller logic.

## Interface
- `CW`, 12: coordinate/counter width; every total minus 1 must fit in CW bits.
- `clk_pix`  in  1  pixel clock; the only clock.
- `rst_pix`  in  1  reset, synchronous, active-high.
- `res`  in  2  mode select: 0 = 640x480, 1 = 1920x1080, 2 = 1280x720, 3 = custom.
- `cfg_load`  in  1  one-cycle pulse; captures all `cfg_*` into the pending custom set.
- `cfg_h_act`, `cfg_h_fp`, `cfg_h_sync`, `cfg_h_bp`  in  CW each  custom horizontal widths, in pixels.
- `cfg_v_act`, `cfg_v_fp`, `cfg_v_sync`, `cfg_v_bp`  in  CW each  custom vertical widths, in lines.
- `cfg_hpol`, `cfg_vpol`  in  1 each  custom sync polarity (1 = active-high).
- `irq_line`  in  CW  line number for `line_irq`.
- `sx`, `sy`  out  CW each  current pixel coordinate.
- `hsync`, `vsync`  out  1 each  sync, at the active mode's polarity.
- `de`  out  1  active-video enable.
- `frame_start`  out  1  pulse at pixel (0,0).
- `line_start`  out  1  pulse at every sx = 0.
- `line_irq`  out  1  pulse at sx = 0 and sy = `irq_line`.

## Operation
- Line layout: active, front porch, sync, back porch. H_TOT = act + fp + sync + bp; V is laid out the same way.
- Preset timings (act/fp/sync/bp, polarity):
  - mode 0: H 640/16/96/48, V 480/10/2/33, negative.
  - mode 1: H 1920/88/44/148, V 1080/4/5/36, positive.
  - mode 2: H 1280/110/40/220, V 720/5/5/20, positive.
- Internal counters `hc`/`vc`:
  - `hc` wraps at H_TOT-1.
  - `vc` increments when `hc` wraps, and wraps at V_TOT-1.
- Decode, all for the same pixel:
  - `de` = `hc` < act and `vc` < act.
  - `hsync` is asserted at the active polarity when act+fp ≤ `hc` < act+fp+sync; otherwise it is at the inactive level.
  - `vsync` follows the same rule on `vc`.
- Sync width 0 means the sync is never asserted. Porch width 0 is legal. Custom act < 1 is illegal and its behaviour is undefined.
- Mode switch:
  - The active mode register and the active custom set update only in the last cycle of a frame (`hc` = H_TOT-1 and `vc` = V_TOT-1).
  - At that edge the update takes `res` and the pending set as they stand before the edge.
  - A `cfg_load` in that same cycle becomes pending and takes effect at the following frame boundary.
  - `res` changes mid-frame are ignored until the boundary; the last value wins.
  - Changes to the pending custom set while in mode 0, 1 or 2 have no visible effect.
- Arithmetic: internal sums are CW+1 bits. Configurations whose H_TOT or V_TOT exceeds 2^CW are illegal.

## Timing
- Single output register stage. `sx`, `sy`, `hsync`, `vsync`, `de`, `frame_start`, `line_start` and `line_irq` are registered and mutually aligned; all describe the same pixel in the same cycle.
- Reset values:
  - counters, `sx`, `sy` = 0; `de` = 0.
  - `hsync` and `vsync` = 1 (inactive level for mode 0).
  - `frame_start`, `line_start`, `line_irq` = 0.
  - active mode = 0; pending custom set = 0.
- First clock edge with `rst_pix` low: outputs show pixel (0,0) with `de` = 1 and `frame_start` = 1.
- Reset asserted mid-frame: all outputs take their reset values on the next edge, and pending configuration is cleared.
- Polarity flips between modes happen on the frame-boundary edge. Sync is inactive at that point in every preset (back porch), so there is no glitch.
- Latency from `res` change to new timing: up to one frame plus one cycle.

## Configuration
- `SCRN_TIMING_LINE_IRQ_EN`:
  - Defined: the `irq_line` compare is built. `line_irq` pulses for one cycle, aligned with `line_start`, when `sy` = `irq_line`. Values of `irq_line` ≥ V_TOT never fire.
  - Undefined: ports are retained, `line_irq` is tied 0 and `irq_line` is ignored.

## Test plan
- Reset release in mode 0: `frame_start` at (0,0). `de` high for exactly 640 cycles per line. `hsync` low for 96 cycles starting at sx = 656. `vsync` low on lines 490–491. Frame length 800×525.
- `res` 0→2 at line 100: mode 0 timing continues to (799,524). The next frame is 1650×750, with `hsync` high at sx = 1390–1429.
- Custom mode: `cfg_load` with H 8/2/2/2, V 4/1/1/1, `hpol` = 1. Select `res` = 3 → after the boundary, 14×7 frames; `hsync` high at sx = 10–11, `vsync` low (`vpol` = 0) at sy = 5.
- `cfg_load` issued in the boundary cycle with new values: the old pending set applies for one frame, and the new set applies from the frame after.
- With the macro defined and `irq_line` = 3 in the custom mode above: exactly one `line_irq` pulse per frame, at (0,3). With `irq_line` = 9: none.
- `rst_pix` asserted mid-line in mode 1: the next cycle shows `sx` = `sy` = 0, `de` = 0, syncs = 1, and the mode reverts to 0.
